// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the memory stage codebase slice.
//   - word_t          : 64-bit machine word
//   - ICODE_*         : instruction codes HALT..POPQ
//   - stat_t          : processor status codes (AOK/HLT/ADR/INS)
//   - mem_op_t        : data-memory access kind derived from icode
//   - helper functions: op decode, address-source select, status priority
package y86_pkg;

  typedef logic [63:0] word_t;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  typedef enum logic [1:0] {
    MEM_NONE,
    MEM_READ,
    MEM_WRITE
  } mem_op_t;

  function automatic mem_op_t decode_mem_op(input logic [3:0] icode);
    case (icode)
      ICODE_MRMOVQ, ICODE_RET, ICODE_POPQ:   return MEM_READ;
      ICODE_RMMOVQ, ICODE_PUSHQ, ICODE_CALL: return MEM_WRITE;
      default:                               return MEM_NONE;
    endcase
  endfunction

  // ret and popq address memory through the stack pointer carried in valA;
  // every other memory op uses the ALU result valE.
  function automatic logic addr_from_vala(input logic [3:0] icode);
    return (icode == ICODE_RET) || (icode == ICODE_POPQ);
  endfunction

  // Address errors dominate, then invalid instruction, then halt.
  function automatic stat_t calc_stat(input logic imem_error,
                                      input logic dmem_error,
                                      input logic instr_valid,
                                      input logic halt);
    if (imem_error || dmem_error) return STAT_ADR;
    else if (!instr_valid)        return STAT_INS;
    else if (halt)                return STAT_HLT;
    else                          return STAT_AOK;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Execute -> memory -> writeback handshake bundle for the memory stage.
//   Request side : in_valid/in_ready, icode, valE, valA, valP and the fetch
//                  flags halt_in, instr_valid_in, imem_error_in.
//   Response side: out_valid/out_ready, valM, dmem_error, stat.
// master = upstream/downstream pipeline logic, slave = memory_stage.
interface memory_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [63:0] valE;
  logic [63:0] valA;
  logic [63:0] valP;
  logic        halt_in;
  logic        instr_valid_in;
  logic        imem_error_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] valM;
  logic        dmem_error;
  logic [2:0]  stat;

  modport master (
    output in_valid, icode, valE, valA, valP,
           halt_in, instr_valid_in, imem_error_in, out_ready,
    input  in_ready, out_valid, valM, dmem_error, stat
  );

  modport slave (
    input  in_valid, icode, valE, valA, valP,
           halt_in, instr_valid_in, imem_error_in, out_ready,
    output in_ready, out_valid, valM, dmem_error, stat
  );
endinterface

// File: rtl/data_mem.sv
// Byte-addressed, little-endian data memory for the memory stage.
//   clk   : write clock
//   we    : write enable, commits all 8 bytes of wdata at addr on posedge
//   addr  : byte address of the least significant byte
//   wdata : 64-bit store data
//   rdata : 64-bit combinational read data (bytes addr..addr+7, LE)
module data_mem #(
  parameter int MEM_BYTES = 1024,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [7:0] mem [MEM_BYTES];

  always_comb begin
    // NOTE: default assignment first so no latch is inferred.
    rdata = '0;
    for (int i = 0; i < 8; i++) begin
      rdata[8*i +: 8] = mem[addr + AW'(i)];
    end
  end

  // NOTE: the RAM array is deliberately not reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        mem[addr + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/memory_stage.sv
// SEQ Y86-64 memory stage: accepts execute results, performs an optional
// multi-cycle data-memory read or write, and returns valM plus stat.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : memory_stage_if.slave (request handshake in, response out)
// Parameters:
//   MEM_BYTES  : data memory size in bytes
//   MEM_LAT    : wait cycles per memory access (1..15)
// Build option:
//   MEM_ALIGN_CHECK_EN : when defined, memory ops with addr[2:0] != 0 are
//                        flagged as address errors; otherwise unaligned
//                        accesses are legal byte-wise LE accesses.
module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int MEM_LAT   = 2
) (
  input logic           clk,
  input logic           rst_n,
  memory_stage_if.slave bus
);

  localparam int    AW       = $clog2(MEM_BYTES);
  localparam word_t ADDR_MAX = word_t'(MEM_BYTES - 8);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;
  mem_op_t       op_q;
  logic [AW-1:0] addr_q;
  word_t         wdata_q;
  logic          err_q;
  logic          halt_q;
  logic          instr_valid_q;
  logic          imem_error_q;

  // Request decode, evaluated on the live inputs while IDLE.
  mem_op_t req_op;
  word_t   req_addr;
  word_t   req_wdata;
  logic    req_err;

  assign req_op    = decode_mem_op(bus.icode);
  assign req_addr  = addr_from_vala(bus.icode) ? bus.valA : bus.valE;
  assign req_wdata = (bus.icode == ICODE_CALL) ? bus.valP : bus.valA;

  always_comb begin
    req_err = 1'b0;
    if (req_op != MEM_NONE) begin
      // Full 64-bit unsigned compare: huge addresses must not wrap into range.
`ifdef MEM_ALIGN_CHECK_EN
      req_err = (req_addr > ADDR_MAX) || (req_addr[2:0] != 3'b000);
`else
      req_err = (req_addr > ADDR_MAX);
`endif
    end
  end

  // Memory port: reads and writes both complete on the last WAIT edge.
  // rst_n gates the write so a reset on that same edge drops the commit.
  logic  mem_we;
  word_t mem_rdata;

  assign mem_we = rst_n && (state == S_WAIT) && (cnt == 4'd0) &&
                  (op_q == MEM_WRITE) && !err_q;

  data_mem #(
    .MEM_BYTES (MEM_BYTES)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      op_q           <= MEM_NONE;
      addr_q         <= '0;
      wdata_q        <= '0;
      err_q          <= 1'b0;
      halt_q         <= 1'b0;
      instr_valid_q  <= 1'b1;
      imem_error_q   <= 1'b0;
      bus.in_ready   <= 1'b1;
      bus.out_valid  <= 1'b0;
      bus.valM       <= '0;
      bus.dmem_error <= 1'b0;
      bus.stat       <= STAT_AOK;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q          <= req_op;
            addr_q        <= req_addr[AW-1:0];
            wdata_q       <= req_wdata;
            err_q         <= req_err;
            halt_q        <= bus.halt_in;
            instr_valid_q <= bus.instr_valid_in;
            imem_error_q  <= bus.imem_error_in;
            bus.in_ready  <= 1'b0;
            if (req_op != MEM_NONE) begin
              state <= S_WAIT;
              cnt   <= 4'(MEM_LAT - 1);
            end else begin
              // No memory access: respond on the very next cycle.
              state          <= S_RESP;
              bus.out_valid  <= 1'b1;
              bus.valM       <= '0;
              bus.dmem_error <= 1'b0;
              bus.stat       <= calc_stat(bus.imem_error_in, 1'b0,
                                          bus.instr_valid_in, bus.halt_in);
            end
          end
        end

        S_WAIT: begin
          if (cnt == 4'd0) begin
            state          <= S_RESP;
            bus.out_valid  <= 1'b1;
            bus.dmem_error <= err_q;
            bus.valM       <= (op_q == MEM_READ && !err_q) ? mem_rdata : '0;
            bus.stat       <= calc_stat(imem_error_q, err_q,
                                        instr_valid_q, halt_q);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_RESP: begin
          // Outputs hold until the consumer takes them.
          if (bus.out_ready) begin
            state         <= S_IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end

        default: begin
          state         <= S_IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage (MEM_BYTES=1024, MEM_LAT=2).
// Expected responses are computed from a local byte-array model and pushed
// to a scoreboard queue when an op is driven; they are popped and compared
// when the stage presents out_valid. Honors MEM_ALIGN_CHECK_EN.
module tb_memory_stage;
  import y86_pkg::*;

  localparam int MEM_BYTES = 1024;
  localparam int MEM_LAT   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_stage_if bus();

  memory_stage #(
    .MEM_BYTES (MEM_BYTES),
    .MEM_LAT   (MEM_LAT)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [63:0] valm;
    logic        err;
    logic [2:0]  stat;
    int          lat;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_mem [MEM_BYTES];

  function automatic logic [63:0] model_read(input logic [63:0] a);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = model_mem[int'(a[15:0]) + i];
    return r;
  endfunction

  task automatic idle_inputs();
    bus.in_valid       = 1'b0;
    bus.icode          = 4'h1;
    bus.valE           = '0;
    bus.valA           = '0;
    bus.valP           = '0;
    bus.halt_in        = 1'b0;
    bus.instr_valid_in = 1'b1;
    bus.imem_error_in  = 1'b0;
    bus.out_ready      = 1'b1;
  endtask

  // Drives one op, scoreboards its expected response, and checks the
  // response, its latency, and the handshake around it. hold>0 keeps
  // out_ready low for that many cycles after out_valid appears.
  task automatic run_op(input string name, input logic [3:0] ic,
                        input logic [63:0] ve, input logic [63:0] va,
                        input logic [63:0] vp, input logic h,
                        input logic iv, input logic im, input int hold);
    exp_t        e;
    exp_t        g;
    int          kind;
    logic [63:0] addr;
    logic [63:0] wd;
    logic        err;
    int          lat;
    logic [63:0] vm_seen;
    logic [2:0]  st_seen;

    case (ic)
      4'h5, 4'h9, 4'hB: kind = 1;
      4'h4, 4'hA, 4'h8: kind = 2;
      default:          kind = 0;
    endcase
    addr = (ic == 4'h9 || ic == 4'hB) ? va : ve;
    wd   = (ic == 4'h8) ? vp : va;
    err  = (kind != 0) && (addr > 64'(MEM_BYTES - 8));
`ifdef MEM_ALIGN_CHECK_EN
    if (kind != 0 && addr[2:0] != 3'b000) err = 1'b1;
`endif
    e.name = name;
    e.err  = err;
    e.valm = (kind == 1 && !err) ? model_read(addr) : 64'h0;
    e.lat  = (kind != 0) ? MEM_LAT + 1 : 1;
    if (im || err)  e.stat = 3'd3;
    else if (!iv)   e.stat = 3'd4;
    else if (h)     e.stat = 3'd2;
    else            e.stat = 3'd1;
    if (kind == 2 && !err)
      for (int i = 0; i < 8; i++) model_mem[int'(addr[15:0]) + i] = wd[8*i +: 8];
    exp_q.push_back(e);

    @(negedge clk);
    bus.icode          = ic;
    bus.valE           = ve;
    bus.valA           = va;
    bus.valP           = vp;
    bus.halt_in        = h;
    bus.instr_valid_in = iv;
    bus.imem_error_in  = im;
    bus.out_ready      = (hold == 0);
    bus.in_valid       = 1'b1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready before accept: got %b expected 1", name, bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    g = exp_q.pop_front();
    if (bus.out_valid !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: out_valid=%b after %0d cycles, expected 1", g.name, bus.out_valid, lat);
      bus.out_ready = 1'b1;
      return;
    end

    n_checks++;
    if (lat !== g.lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", g.name, lat, g.lat);
    end
    n_checks++;
    if (bus.valM !== g.valm) begin
      n_fail++;
      $display("FAIL %s valM: got %h expected %h", g.name, bus.valM, g.valm);
    end
    n_checks++;
    if (bus.dmem_error !== g.err) begin
      n_fail++;
      $display("FAIL %s dmem_error: got %b expected %b", g.name, bus.dmem_error, g.err);
    end
    n_checks++;
    if (bus.stat !== g.stat) begin
      n_fail++;
      $display("FAIL %s stat: got %0d expected %0d", g.name, bus.stat, g.stat);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s in_ready during resp: got %b expected 0", g.name, bus.in_ready);
    end

    vm_seen = bus.valM;
    st_seen = bus.stat;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.valM !== vm_seen || bus.stat !== st_seen ||
          bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s hold cycle %0d: out_valid=%b valM=%h stat=%0d in_ready=%b expected 1/%h/%0d/0",
                 g.name, c, bus.out_valid, bus.valM, bus.stat, bus.in_ready, vm_seen, st_seen);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: out_valid=%b in_ready=%b expected 0/1", g.name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.valM !== 64'h0 ||
        bus.dmem_error !== 1'b0 || bus.stat !== 3'd1) begin
      n_fail++;
      $display("FAIL reset state: in_ready=%b out_valid=%b valM=%h dmem_error=%b stat=%0d expected 1/0/0/0/1",
               bus.in_ready, bus.out_valid, bus.valM, bus.dmem_error, bus.stat);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    run_op("rmmovq_16", 4'h4, 64'd16, 64'h1122334455667788, 64'h0, 0, 1, 0, 0);
    run_op("mrmovq_16", 4'h5, 64'd16, 64'h0, 64'h0, 0, 1, 0, 0);
    n_checks++;
    if (u_dut.u_mem.mem[16] !== 8'h88) begin
      n_fail++;
      $display("FAIL byte16: got %h expected 88", u_dut.u_mem.mem[16]);
    end
  endtask

  task automatic test_call_ret();
    run_op("call_120", 4'h8, 64'd120, 64'h0, 64'h40, 0, 1, 0, 0);
    run_op("ret_120",  4'h9, 64'h0, 64'd120, 64'h0, 0, 1, 0, 0);
    run_op("pushq_400", 4'hA, 64'd400, 64'hDEAD_BEEF_0BAD_F00D, 64'h0, 0, 1, 0, 0);
    run_op("popq_400",  4'hB, 64'h0, 64'd400, 64'h0, 0, 1, 0, 0);
  endtask

  task automatic test_addr_error();
    run_op("pre_1016",   4'h4, 64'd1016, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0, 0, 1, 0, 0);
    run_op("rd_1016",    4'h5, 64'd1016, 64'h0, 64'h0, 0, 1, 0, 0);
    run_op("rd_1020",    4'h5, 64'd1020, 64'h0, 64'h0, 0, 1, 0, 0);
    run_op("wr_1017",    4'h4, 64'd1017, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 1, 0, 0);
    run_op("rd_1016_b",  4'h5, 64'd1016, 64'h0, 64'h0, 0, 1, 0, 0);
    run_op("rd_huge",    4'h5, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0, 0, 1, 0, 0);
    run_op("popq_1024",  4'hB, 64'h0, 64'd1024, 64'h0, 0, 1, 0, 0);
  endtask

  task automatic test_nonmem();
    run_op("opq_halt",   4'h6, 64'h55, 64'h66, 64'h77, 1, 1, 0, 0);
    run_op("opq_ins",    4'h6, 64'h55, 64'h66, 64'h77, 0, 0, 0, 0);
    run_op("nop_imem",   4'h1, 64'h0, 64'h0, 64'h0, 0, 1, 1, 0);
    run_op("ins_over_hlt", 4'h0, 64'h0, 64'h0, 64'h0, 1, 0, 0, 0);
    run_op("irmovq_aok", 4'h3, 64'h1234, 64'h0, 64'h0, 0, 1, 0, 0);
  endtask

  task automatic test_backpressure();
    run_op("bp_read", 4'h5, 64'd16, 64'h0, 64'h0, 0, 1, 0, 5);
    run_op("bp_opq",  4'h6, 64'h0, 64'h0, 64'h0, 1, 1, 0, 5);
  endtask

  task automatic test_reset_mid_access();
    run_op("pre_200", 4'h4, 64'd200, 64'h0102_0304_0506_0708, 64'h0, 0, 1, 0, 0);
    @(negedge clk);
    bus.icode    = 4'h4;
    bus.valE     = 64'd200;
    bus.valA     = 64'hFEED_FACE_CAFE_BABE;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wait state: in_ready=%b out_valid=%b expected 0/0", bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.valM !== 64'h0 ||
        bus.dmem_error !== 1'b0 || bus.stat !== 3'd1) begin
      n_fail++;
      $display("FAIL mid reset: in_ready=%b out_valid=%b valM=%h dmem_error=%b stat=%0d expected 1/0/0/0/1",
               bus.in_ready, bus.out_valid, bus.valM, bus.dmem_error, bus.stat);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("rd_200_kept", 4'h5, 64'd200, 64'h0, 64'h0, 0, 1, 0, 0);
  endtask

  task automatic test_unaligned();
    run_op("wr_8",  4'h4, 64'd8,  64'h8877_6655_4433_2211, 64'h0, 0, 1, 0, 0);
    run_op("wr_16", 4'h4, 64'd16, 64'hFFEE_DDCC_BBAA_9900, 64'h0, 0, 1, 0, 0);
    run_op("rd_12", 4'h5, 64'd12, 64'h0, 64'h0, 0, 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_op($sformatf("b2b_wr%0d", i), 4'h4, 64'(300 + 8*i),
             {$urandom, $urandom}, 64'h0, 0, 1, 0, 0);
    for (int i = 3; i >= 0; i--)
      run_op($sformatf("b2b_rd%0d", i), 4'h5, 64'(300 + 8*i),
             64'h0, 64'h0, 0, 1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_call_ret();
    test_addr_error();
    test_nonmem();
    test_backpressure();
    test_reset_mid_access();
    test_unaligned();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
